// File: rtl/register_file.sv
// Multi-ported register file for the datapath: 2**ADDR_WIDTH entries of
// DATA_WIDTH bits, two combinational read ports and one synchronous write port.
//
// Ports:
//   clk         system clock, all state updates on the rising edge
//   rst         synchronous active-high reset, clears every entry
//   write_en    write enable for the write port
//   write_adr   destination entry for the write
//   write_data  data to store
//   read_adr_a  entry selected onto reg_a
//   read_adr_b  entry selected onto reg_b
//   reg_a       contents of entry read_adr_a (combinational)
//   reg_b       contents of entry read_adr_b (combinational)
module register_file #(
    parameter int unsigned DATA_WIDTH = 48,
    parameter int unsigned ADDR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  write_en,
    input  logic [ADDR_WIDTH-1:0] write_adr,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic [ADDR_WIDTH-1:0] read_adr_a,
    input  logic [ADDR_WIDTH-1:0] read_adr_b,
    output logic [DATA_WIDTH-1:0] reg_a,
    output logic [DATA_WIDTH-1:0] reg_b
);

    localparam int unsigned NUM_ENTRIES = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] entries [NUM_ENTRIES];

    // Storage update; reset wins over a coincident write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_ENTRIES); i++) begin
                entries[i] <= '0;
            end
        end else if (write_en) begin
            entries[write_adr] <= write_data;
        end
    end

    // Read ports see stored state only; a same-cycle write is not bypassed.
    assign reg_a = entries[read_adr_a];
    assign reg_b = entries[read_adr_b];

endmodule

// File: tb/tb_register_file.sv
module tb_register_file;

    localparam int unsigned DW = 48;
    localparam int unsigned AW = 2;
    localparam int unsigned N  = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          write_en;
    logic [AW-1:0] write_adr;
    logic [DW-1:0] write_data;
    logic [AW-1:0] read_adr_a;
    logic [AW-1:0] read_adr_b;
    logic [DW-1:0] reg_a;
    logic [DW-1:0] reg_b;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: plain array of register contents.
    logic [DW-1:0] model [N];

    register_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .write_en   (write_en),
        .write_adr  (write_adr),
        .write_data (write_data),
        .read_adr_a (read_adr_a),
        .read_adr_b (read_adr_b),
        .reg_a      (reg_a),
        .reg_b      (reg_b)
    );

    always #5 clk = ~clk;

    // One rising edge; the model takes the edge's effect after it passes.
    task automatic step();
        logic [DW-1:0] nxt [N];
        for (int i = 0; i < int'(N); i++) nxt[i] = model[i];
        if (rst) begin
            for (int i = 0; i < int'(N); i++) nxt[i] = '0;
        end else if (write_en) begin
            nxt[write_adr] = write_data;
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < int'(N); i++) model[i] = nxt[i];
    endtask

    task automatic test_reset();
        rst = 1'b0;
        write_en = 1'b1;
        for (int i = 0; i < int'(N); i++) begin
            write_adr  = AW'(i);
            write_data = {16'($urandom), 32'($urandom)} | 48'h1;
            step();
        end
        write_en = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < int'(N); i++) begin
            read_adr_a = AW'(i);
            read_adr_b = AW'(N - 1 - i);
            #1;
            vectors++;
            if (reg_a !== 48'h0) begin
                miscompares++;
                $display("FAIL reset_a[%0d]: got %h expected %h", i, reg_a, 48'h0);
            end
            vectors++;
            if (reg_b !== 48'h0) begin
                miscompares++;
                $display("FAIL reset_b[%0d]: got %h expected %h", N - 1 - i, reg_b, 48'h0);
            end
        end
    endtask

    task automatic test_write_all_read_all();
        write_en = 1'b1;
        for (int i = 0; i < int'(N); i++) begin
            write_adr  = AW'(i);
            write_data = DW'(i + 1);
            step();
        end
        write_en = 1'b0;
        read_adr_a = 2'd0;
        read_adr_b = 2'd1;
        #1;
        vectors++;
        if (reg_a !== 48'h1) begin
            miscompares++;
            $display("FAIL wall_a0: got %h expected %h", reg_a, 48'h1);
        end
        vectors++;
        if (reg_b !== 48'h2) begin
            miscompares++;
            $display("FAIL wall_b1: got %h expected %h", reg_b, 48'h2);
        end
        read_adr_a = 2'd2;
        read_adr_b = 2'd3;
        #1;
        vectors++;
        if (reg_a !== 48'h3) begin
            miscompares++;
            $display("FAIL wall_a2: got %h expected %h", reg_a, 48'h3);
        end
        vectors++;
        if (reg_b !== 48'h4) begin
            miscompares++;
            $display("FAIL wall_b3: got %h expected %h", reg_b, 48'h4);
        end
    endtask

    task automatic test_write_disable();
        write_en   = 1'b0;
        write_adr  = 2'd1;
        write_data = 48'hFFFF_FFFF_FFFF;
        repeat (4) step();
        read_adr_a = 2'd1;
        read_adr_b = 2'd0;
        #1;
        vectors++;
        if (reg_a !== 48'h2) begin
            miscompares++;
            $display("FAIL wdis_e1: got %h expected %h", reg_a, 48'h2);
        end
        vectors++;
        if (reg_b !== 48'h1) begin
            miscompares++;
            $display("FAIL wdis_e0: got %h expected %h", reg_b, 48'h1);
        end
    endtask

    task automatic test_read_during_write();
        write_en   = 1'b1;
        write_adr  = 2'd2;
        write_data = 48'hABCD_0000_1234;
        read_adr_a = 2'd2;
        read_adr_b = 2'd2;
        #1;
        vectors++;
        if (reg_a !== 48'h3) begin
            miscompares++;
            $display("FAIL rdw_before: got %h expected %h", reg_a, 48'h3);
        end
        step();
        write_en = 1'b0;
        #1;
        vectors++;
        if (reg_a !== 48'hABCD_0000_1234) begin
            miscompares++;
            $display("FAIL rdw_after_a: got %h expected %h", reg_a, 48'hABCD_0000_1234);
        end
        vectors++;
        if (reg_b !== 48'hABCD_0000_1234) begin
            miscompares++;
            $display("FAIL rdw_after_b: got %h expected %h", reg_b, 48'hABCD_0000_1234);
        end
    endtask

    task automatic test_same_address();
        read_adr_a = 2'd3;
        read_adr_b = 2'd3;
        #1;
        vectors++;
        if (reg_a !== 48'h4 || reg_b !== 48'h4) begin
            miscompares++;
            $display("FAIL same_addr: got a=%h b=%h expected %h", reg_a, reg_b, 48'h4);
        end
        write_en   = 1'b1;
        write_adr  = 2'd0;
        write_data = 48'hFFFF_FFFF_FFFF;
        step();
        write_en   = 1'b0;
        read_adr_a = 2'd0;
        read_adr_b = 2'd0;
        #1;
        vectors++;
        if (reg_a !== 48'hFFFF_FFFF_FFFF || reg_b !== 48'hFFFF_FFFF_FFFF) begin
            miscompares++;
            $display("FAIL full_width: got a=%h b=%h expected %h", reg_a, reg_b, 48'hFFFF_FFFF_FFFF);
        end
    endtask

    task automatic test_reset_priority();
        rst        = 1'b1;
        write_en   = 1'b1;
        write_adr  = 2'd0;
        write_data = 48'h5;
        step();
        rst      = 1'b0;
        write_en = 1'b0;
        read_adr_a = 2'd0;
        read_adr_b = 2'd2;
        #1;
        vectors++;
        if (reg_a !== 48'h0) begin
            miscompares++;
            $display("FAIL rst_prio_e0: got %h expected %h", reg_a, 48'h0);
        end
        vectors++;
        if (reg_b !== 48'h0) begin
            miscompares++;
            $display("FAIL rst_prio_e2: got %h expected %h", reg_b, 48'h0);
        end
    endtask

    // Random traffic including back-to-back writes, checked before every edge.
    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            rst        = ($urandom_range(0, 29) == 0);
            write_en   = ($urandom_range(0, 3) != 0);
            write_adr  = AW'($urandom_range(0, N - 1));
            write_data = {16'($urandom), 32'($urandom)};
            read_adr_a = AW'($urandom_range(0, N - 1));
            read_adr_b = AW'($urandom_range(0, N - 1));
            #1;
            vectors++;
            if (reg_a !== model[read_adr_a] || reg_b !== model[read_adr_b]) begin
                miscompares++;
                $display("FAIL random[%0d]: got a=%h b=%h expected a=%h b=%h",
                         c, reg_a, reg_b, model[read_adr_a], model[read_adr_b]);
            end
            step();
        end
        rst = 1'b0;
        write_en = 1'b0;
        for (int i = 0; i < int'(N); i++) begin
            read_adr_a = AW'(i);
            read_adr_b = AW'(i);
            #1;
            vectors++;
            if (reg_a !== model[i] || reg_b !== model[i]) begin
                miscompares++;
                $display("FAIL random_final[%0d]: got a=%h b=%h expected %h", i, reg_a, reg_b, model[i]);
            end
        end
    endtask

    initial begin
        rst        = 1'b1;
        write_en   = 1'b0;
        write_adr  = '0;
        write_data = '0;
        read_adr_a = '0;
        read_adr_b = '0;
        for (int i = 0; i < int'(N); i++) model[i] = 'x;
        step();
        rst = 1'b0;
        test_reset();
        test_write_all_read_all();
        test_write_disable();
        test_read_during_write();
        test_same_address();
        test_reset_priority();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- Small multi-ported register file for the processor datapath: 4 entries × 48 bits.
- Two independent combinational read ports (A, B) feed the ALU operands.
- One synchronous write port is used for writeback.
- Single clock domain with synchronous active-high reset.

Parameters:
- DATA_WIDTH, 48, width of each register and of every data port.
- ADDR_WIDTH, 2, address width; number of entries = 2**ADDR_WIDTH (default 4).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- write_en  input  1  write enable for the write port.
- write_adr  input  ADDR_WIDTH  destination entry for the write.
- write_data  input  DATA_WIDTH  data to store.
- read_adr_a  input  ADDR_WIDTH  entry selected onto reg_a.
- read_adr_b  input  ADDR_WIDTH  entry selected onto reg_b.
- reg_a  output  DATA_WIDTH  contents of entry read_adr_a.
- reg_b  output  DATA_WIDTH  contents of entry read_adr_b.

Behaviour:
- Interface: one clock; reset is synchronous and active-high (ports clk, rst).
- Storage: 2**ADDR_WIDTH registers of DATA_WIDTH bits each. No hardwired-zero entry; every entry is writable, including entry 0.
- Reset: at a rising clk edge with rst=1, all entries clear to 0. Consequently reg_a = reg_b = 0 after that edge, for any read address.
- Reset has priority over a write in the same cycle; the write is dropped.
- rst asserted mid-operation discards all previously written contents at the next edge.
- Write: at a rising clk edge with rst=0 and write_en=1, entry[write_adr] <= write_data.
  - All other entries hold their value.
  - write_en=0 means no entry changes, regardless of write_adr and write_data.
- Read: reg_a = entry[read_adr_a] and reg_b = entry[read_adr_b], purely combinational.
  - Outputs change in the same cycle as the address changes, zero-cycle latency.
- Both read ports may address the same entry simultaneously; both return the identical value.
- Read-during-write to the same entry: no bypass.
  - Before the edge, the read returns the old stored value.
  - After the edge, it returns the new value.
  - Write latency is one edge; data is visible on the read ports immediately after the capturing edge.
- Full address range is valid; there are no out-of-range conditions and no wrap-around concerns.
- Back-to-back writes on consecutive edges to different or the same entries are all honoured; the last write wins.
- No handshake, no stall, no error outputs.

Test Plan:
- Reset: assert rst for one edge after arbitrary writes → all four entries read 0 on both ports, for every address.
- Write all, read all: write_en=1, write entries 0..3 with 48'h1, 48'h2, 48'h3, 48'h4 on consecutive edges. Then write_en=0 with read_adr_a=0, read_adr_b=1 → reg_a=48'h1, reg_b=48'h2. Then read_adr_a=2, read_adr_b=3 → reg_a=48'h3, reg_b=48'h4.
- Write disable: write_en=0, write_adr=1, write_data=48'hFFFF_FFFF_FFFF, clock several edges → entry 1 still 48'h2.
- Read-during-write: entry 2 = 48'h3; set write_adr=2, write_data=48'hABCD_0000_1234, read_adr_a=2 → reg_a=48'h3 before the edge and 48'hABCD_0000_1234 right after it.
- Same address on both ports: read_adr_a = read_adr_b = 3 → reg_a = reg_b = 48'h4. Also check full-width data: write 48'hFFFF_FFFF_FFFF to entry 0 and read it back exactly.
- Reset vs write priority: rst=1 and write_en=1 with write_adr=0, write_data=48'h5 on the same edge → entry 0 reads 0.
